// File: rtl/mem_fifo_ctrl.sv
// FIFO controller that keeps its storage in an external single-port-per-direction memory.
// Optional sticky error flag: define MEM_FIFO_ERROR_FLAG_EN.
module mem_fifo_ctrl #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int DEPTH        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_req,
    input  logic [WORD_SIZE-1:0]    push_data,
    output logic                    push_ready,
    input  logic                    pop_req,
    output logic                    pop_ready,
    output logic [WORD_SIZE-1:0]    pop_data,
    output logic                    pop_valid,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    error,
    output logic                    mem_w_en,
    output logic [ADDRESS_SIZE-1:0] mem_w_addr,
    output logic [WORD_SIZE-1:0]    mem_w_data,
    input  logic                    mem_w_ready,
    output logic                    mem_r_en,
    output logic [ADDRESS_SIZE-1:0] mem_r_addr,
    input  logic [WORD_SIZE-1:0]    mem_r_data,
    input  logic                    mem_r_ready,
    output logic [1:0]              w_state_dbg,
    output logic [1:0]              r_state_dbg
);

    // Handshake: a push (pop) is taken on a rising edge where push_req & push_ready
    // (pop_req & pop_ready); requests while not ready are dropped, never queued.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } eng_state_t;

    localparam logic [ADDRESS_SIZE-1:0] LAST_IDX  = ADDRESS_SIZE'(DEPTH - 1);
    localparam logic [ADDRESS_SIZE-1:0] PTR_ONE   = ADDRESS_SIZE'(1);
    localparam logic [ADDRESS_SIZE:0]   CNT_ONE   = (ADDRESS_SIZE + 1)'(1);
    localparam logic [ADDRESS_SIZE:0]   DEPTH_CNT = (ADDRESS_SIZE + 1)'(DEPTH);

    eng_state_t w_state, w_next, r_state, r_next;
    logic [ADDRESS_SIZE-1:0] head, tail;
    logic [ADDRESS_SIZE:0]   count_next;
    logic push_fire, w_commit, pop_fire, r_done;
    logic w_busy;

    assign w_busy      = (w_state != IDLE);
    assign full        = ((count + (ADDRESS_SIZE + 1)'(w_busy)) == DEPTH_CNT);
    assign empty       = (count == '0);
    assign push_ready  = (w_state == IDLE) && mem_w_ready && !full;
    assign pop_ready   = (r_state == IDLE) && mem_r_ready && !empty;
    assign mem_w_en    = (w_state == ISSUE);
    assign mem_r_en    = (r_state == ISSUE);
    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

    always_comb begin
        w_next    = w_state;
        push_fire = 1'b0;
        w_commit  = 1'b0;
        case (w_state)
            IDLE:  if (push_req && push_ready) begin
                       push_fire = 1'b1;
                       w_next    = ISSUE;
                   end
            ISSUE: w_next = BUSY;
            BUSY:  if (mem_w_ready) begin
                       w_commit = 1'b1;
                       w_next   = IDLE;
                   end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        r_next   = r_state;
        pop_fire = 1'b0;
        r_done   = 1'b0;
        case (r_state)
            IDLE:  if (pop_req && pop_ready) begin
                       pop_fire = 1'b1;
                       r_next   = ISSUE;
                   end
            ISSUE: r_next = BUSY;
            BUSY:  if (mem_r_ready) begin
                       r_done = 1'b1;
                       r_next = IDLE;
                   end
            default: r_next = IDLE;
        endcase
    end

    // Only committed writes count, so the reader never sees a slot still being written.
    always_comb begin
        count_next = count;
        if (w_commit && !r_done)
            count_next = count + CNT_ONE;
        else if (!w_commit && r_done)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state    <= IDLE;
            tail       <= '0;
            mem_w_addr <= '0;
            mem_w_data <= '0;
        end else begin
            w_state <= w_next;
            if (push_fire) begin
                mem_w_data <= push_data;
                mem_w_addr <= tail;
            end
            if (w_commit)
                tail <= (tail == LAST_IDX) ? '0 : tail + PTR_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            head       <= '0;
            mem_r_addr <= '0;
            pop_data   <= '0;
            pop_valid  <= 1'b0;
        end else begin
            r_state   <= r_next;
            pop_valid <= r_done;
            if (pop_fire)
                mem_r_addr <= head;
            if (r_done) begin
                pop_data <= mem_r_data;
                head     <= (head == LAST_IDX) ? '0 : head + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= count_next;
    end

`ifdef MEM_FIFO_ERROR_FLAG_EN
    logic error_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            error_q <= 1'b0;
        else if ((push_req && full) || (pop_req && empty))
            error_q <= 1'b1;
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl with a zero-wait-state memory model.
// Expected error flag follows MEM_FIFO_ERROR_FLAG_EN.
module tb_mem_fifo_ctrl;

    logic       clock;
    logic       reset;
    logic       push_req;
    logic [7:0] push_data;
    logic       push_ready;
    logic       pop_req;
    logic       pop_ready;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [4:0] count;
    logic       full, empty, error;
    logic       mem_w_en;
    logic [3:0] mem_w_addr;
    logic [7:0] mem_w_data;
    logic       mem_r_en;
    logic [3:0] mem_r_addr;
    logic [7:0] mem_r_data;
    logic       mem_rdy;
    logic [1:0] w_state_dbg, r_state_dbg;

`ifdef MEM_FIFO_ERROR_FLAG_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    int vectors = 0;
    int fails   = 0;
    logic [7:0] exp_q[$];
    int exp_head  = 0;
    int exp_tail  = 0;
    int exp_count = 0;
    logic [7:0] mem [16];

    mem_fifo_ctrl #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .DEPTH(16)) dut (
        .clock(clock), .reset(reset),
        .push_req(push_req), .push_data(push_data), .push_ready(push_ready),
        .pop_req(pop_req), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
        .count(count), .full(full), .empty(empty), .error(error),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_w_ready(mem_rdy),
        .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .mem_r_ready(mem_rdy),
        .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // zero-wait-state memory: synchronous write, registered read
    always @(posedge clock) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks; each is entered and left on a falling edge
    task automatic push(input logic [7:0] d);
        int n = 0;
        while (!push_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("push_ready_wait", push_ready, 1);
        push_req  = 1'b1;
        push_data = d;
        @(negedge clock);
        push_req = 1'b0;
        check("w_issue_en", mem_w_en, 1);
        check("w_issue_addr", mem_w_addr, exp_tail);
        check("w_issue_data", mem_w_data, d);
        exp_q.push_back(d);
        exp_tail = (exp_tail + 1) % 16;
        exp_count++;
        @(negedge clock);
        @(negedge clock);
        check("push_count", count, exp_count);
    endtask

    task automatic pop();
        int n = 0;
        logic [7:0] e;
        while (!pop_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("pop_ready_wait", pop_ready, 1);
        pop_req = 1'b1;
        @(negedge clock);
        pop_req = 1'b0;
        check("r_issue_en", mem_r_en, 1);
        check("r_issue_addr", mem_r_addr, exp_head);
        @(negedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        check("pop_valid", pop_valid, 1);
        check("pop_data", pop_data, e);
        exp_head = (exp_head + 1) % 16;
        exp_count--;
        check("pop_count", count, exp_count);
    endtask

    initial begin
        logic [7:0] e;
        reset = 1'b1; mem_rdy = 1'b0;
        push_req = 1'b0; push_data = '0; pop_req = 1'b0;

        // reset state
        @(negedge clock); @(negedge clock);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_w_en", mem_w_en, 0);
        check("rst_r_en", mem_r_en, 0);
        check("rst_w_addr", mem_w_addr, 0);
        check("rst_error", error, 0);
        check("rst_states", {w_state_dbg, r_state_dbg}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("init_push_ready", push_ready, 0);
        check("init_pop_ready", pop_ready, 0);
        mem_rdy = 1'b1;
        #1;
        check("ready_push_ready", push_ready, 1);
        check("ready_pop_ready", pop_ready, 0);
        check("ready_empty", empty, 1);
        @(negedge clock);

        // latency and pop_req held while first write is in flight
        push_req = 1'b1; push_data = 8'hA5;
        @(negedge clock);
        push_req = 1'b0; pop_req = 1'b1;
        check("a_w_en", mem_w_en, 1);
        check("a_w_data", mem_w_data, 8'hA5);
        check("a_pop_ready_issue", pop_ready, 0);
        @(negedge clock);
        check("a_w_en_one_cycle", mem_w_en, 0);
        check("a_count_busy", count, 0);
        check("a_pop_ready_busy", pop_ready, 0);
        @(negedge clock);
        check("a_count_commit", count, 1);
        check("a_pop_ready_commit", pop_ready, 1);
        @(negedge clock);
        pop_req = 1'b0;
        check("a_r_en", mem_r_en, 1);
        check("a_r_addr", mem_r_addr, 0);
        @(negedge clock);
        check("a_pop_valid_early", pop_valid, 0);
        @(negedge clock);
        check("a_pop_valid", pop_valid, 1);
        check("a_pop_data", pop_data, 8'hA5);
        check("a_count_done", count, 0);
        @(negedge clock);
        check("a_pop_valid_pulse", pop_valid, 0);
        check("a_pop_data_hold", pop_data, 8'hA5);
        check("a_error", error, ERR_EN);
        exp_head = 1; exp_tail = 1;

        // two words in, two words out
        push(8'hA5);
        push(8'h3C);
        check("b_count2", count, 2);
        pop();
        pop();
        check("b_empty", empty, 1);

        // fill to DEPTH, then an overflow attempt
        for (int i = 0; i < 15; i++) push(8'(8'h40 + i));
        push_req = 1'b1; push_data = 8'h4F;
        @(negedge clock);
        push_req = 1'b0;
        check("c_full_inflight", full, 1);
        check("c_count_inflight", count, 15);
        check("c_push_ready_inflight", push_ready, 0);
        exp_q.push_back(8'h4F);
        exp_tail = (exp_tail + 1) % 16;
        exp_count++;
        @(negedge clock); @(negedge clock);
        check("c_count16", count, 16);
        check("c_full", full, 1);
        check("c_push_ready", push_ready, 0);
        push_req = 1'b1; push_data = 8'hFF;
        @(negedge clock);
        push_req = 1'b0;
        check("c_over_w_en", mem_w_en, 0);
        check("c_over_state", w_state_dbg, 0);
        check("c_over_count", count, 16);
        check("c_over_error", error, ERR_EN);
        for (int i = 0; i < 16; i++) pop();
        check("c_empty", empty, 1);
        pop_req = 1'b1;
        @(negedge clock);
        pop_req = 1'b0;
        check("c_under_r_en", mem_r_en, 0);
        check("c_under_state", r_state_dbg, 0);
        @(negedge clock); @(negedge clock);
        check("c_under_pop_valid", pop_valid, 0);

        // interleaved stream across pointer wrap
        for (int i = 0; i < 20; i++) begin
            push(8'(i));
            if (i >= 1) pop();
        end
        pop();
        check("d_empty", empty, 1);
        check("d_queue_drained", exp_q.size(), 0);

        // reset while a write is in BUSY with three words stored
        push(8'h01); push(8'h02); push(8'h03);
        check("e_count3", count, 3);
        push_req = 1'b1; push_data = 8'hEE;
        @(negedge clock);
        push_req = 1'b0;
        @(negedge clock);
        check("e_w_busy", w_state_dbg, 2);
        reset = 1'b1; mem_rdy = 1'b0;
        #1;
        check("e_rst_count", count, 0);
        check("e_rst_empty", empty, 1);
        check("e_rst_w_en", mem_w_en, 0);
        check("e_rst_pop_valid", pop_valid, 0);
        check("e_rst_error", error, 0);
        exp_q.delete();
        exp_head = 0; exp_tail = 0; exp_count = 0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("e_init_push_ready", push_ready, 0);
        check("e_pop_valid_after", pop_valid, 0);
        check("e_count_after", count, 0);
        mem_rdy = 1'b1;
        @(negedge clock);
        check("e_push_ready", push_ready, 1);

        // write commit and read completion on the same edge
        push(8'h77);
        push_req = 1'b1; push_data = 8'h88; pop_req = 1'b1;
        @(negedge clock);
        push_req = 1'b0; pop_req = 1'b0;
        check("f_w_addr", mem_w_addr, 1);
        check("f_r_addr", mem_r_addr, 0);
        check("f_both_issue", {mem_w_en, mem_r_en}, 2'b11);
        @(negedge clock); @(negedge clock);
        e = exp_q.pop_front();
        check("f_count_same", count, 1);
        check("f_pop_valid", pop_valid, 1);
        check("f_pop_data", pop_data, e);
        exp_q.push_back(8'h88);
        exp_head = 1; exp_tail = 2; exp_count = 1;
        pop();
        check("f_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
